// File: rtl/jk_seq_pkg.sv
// Shared types and constants for the J-K flop sequencer: FSM states, J/K command
// encoding, the 8-step auto pattern and its expected q trace.
package jk_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STROBE,
        ST_CHECK,
        ST_PASS
`ifdef JK_SEQ_SELFCHECK_EN
        , ST_FAIL
`endif
    } state_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Entry [0] is the first step applied.
    localparam logic [7:0][1:0] PATTERN = {JK_TGL, JK_RST, JK_TGL, JK_TGL,
                                           JK_HOLD, JK_SET, JK_HOLD, JK_RST};

    // q after each step, bit i for step i: 0,0,1,1,0,1,0,1.
    localparam logic [7:0] EXPECT_Q = 8'b1010_1100;

    function automatic logic jk_next(input logic q, input logic [1:0] cmd);
        logic r;
        case (cmd)
            JK_HOLD: r = q;
            JK_RST:  r = 1'b0;
            JK_SET:  r = 1'b1;
            default: r = ~q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/jk_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_HZ/TICK_HZ cycles.
module jk_tick_gen #(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic tick_o
);

    localparam logic [31:0] TERM = 32'(CLK_HZ / TICK_HZ - 1);

    logic [31:0] cnt_q, cnt_d;
    logic        tick_q;

    always_comb begin
        cnt_d = (cnt_q == TERM) ? 32'd0 : cnt_q + 32'd1;
    end

    // tick_q is high exactly in the cycle where cnt_q holds the terminal value.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= 32'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == TERM);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/jk_sequencer.sv
// J-K flop sequencer: manual switch drive or an 8-step auto pattern with a q reference model.
// Define JK_SEQ_SELFCHECK_EN to enable the model comparison, FAIL state and err output.
module jk_sequencer
    import jk_seq_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 1,
    parameter int unsigned SEQ_LEN = 8
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       mode,
    input  logic       start,
    input  logic       sw_j,
    input  logic       sw_k,
    input  logic       jk_q,
    input  logic       jk_qbar,
    output logic       jk_j,
    output logic       jk_k,
    output logic       jk_en,
    output logic [2:0] step,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] LAST_STEP = 3'(SEQ_LEN - 1);

    state_e     state_q;
    logic [2:0] step_q;
    logic       busy_q, done_q;
    logic       j_q, k_q, en_q;
    logic       start_q;
    logic       tick;
    logic       start_rise;
    logic       manual_en;
    logic       fb_ok;

    jk_tick_gen #(
        .CLK_HZ (CLK_HZ),
        .TICK_HZ(TICK_HZ)
    ) u_tick (
        .clk_i (CLOCK_50),
        .rst_ni(RESET_N),
        .tick_o(tick)
    );

    assign start_rise = start & ~start_q;
    assign manual_en  = (state_q == ST_IDLE) & ~mode & tick;

`ifdef JK_SEQ_SELFCHECK_EN
    logic model_q;
    logic err_q;

    // Model follows every strobe, manual or auto, so runs start from a known q.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            model_q <= 1'b0;
        end else if (jk_en) begin
            model_q <= jk_next(model_q, {j_q, k_q});
        end
    end

    assign fb_ok = (jk_q == model_q) && (jk_qbar == ~model_q);
    assign err   = err_q;
`else
    logic unused_fb;
    assign unused_fb = jk_q ^ jk_qbar ^ EXPECT_Q[0];
    assign fb_ok     = 1'b1;
    assign err       = 1'b0;
`endif

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_IDLE;
            step_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            j_q     <= 1'b0;
            k_q     <= 1'b0;
            en_q    <= 1'b0;
            start_q <= 1'b0;
`ifdef JK_SEQ_SELFCHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            start_q <= start;
            en_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!mode) begin
                        j_q <= sw_j;
                        k_q <= sw_k;
                    end else if (start_rise) begin
                        state_q <= ST_LOAD;
                        step_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef JK_SEQ_SELFCHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
                ST_LOAD, ST_STROBE, ST_CHECK: begin
                    if (!mode) begin
                        state_q <= ST_IDLE;
                        step_q  <= 3'd0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
`ifdef JK_SEQ_SELFCHECK_EN
                        err_q   <= 1'b0;
`endif
                    end else if (state_q == ST_LOAD) begin
                        {j_q, k_q} <= PATTERN[step_q];
                        if (tick) begin
                            state_q <= ST_STROBE;
                            en_q    <= 1'b1;
                        end
                    end else if (state_q == ST_STROBE) begin
                        state_q <= ST_CHECK;
                    end else if (!fb_ok) begin
`ifdef JK_SEQ_SELFCHECK_EN
                        state_q <= ST_FAIL;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
`endif
                    end else if (step_q == LAST_STEP) begin
                        state_q <= ST_PASS;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        step_q  <= step_q + 3'd1;
                        state_q <= ST_LOAD;
                    end
                end
                default: begin
                    // PASS and FAIL: wait for a new run or a return to manual.
                    if (!mode) begin
                        state_q <= ST_IDLE;
                    end else if (start_rise) begin
                        state_q <= ST_LOAD;
                        step_q  <= 3'd0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef JK_SEQ_SELFCHECK_EN
                        err_q   <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

    assign jk_j  = j_q;
    assign jk_k  = k_q;
    assign jk_en = en_q | manual_en;
    assign step  = step_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_jk_sequencer.sv
// Directed bench for jk_sequencer with a behavioural J-K flop on the feedback path.
module tb_jk_sequencer;

    localparam int PER = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0, start = 1'b0, sw_j = 1'b0, sw_k = 1'b0;
    logic       jk_q, jk_qbar, jk_j, jk_k, jk_en, busy, done, err;
    logic [2:0] step;
    logic       ff_q;
    logic       force_zero = 1'b0;

    int         n_checks = 0;
    int         n_pass = 0;
    int         pulse_cyc [16];
    logic       qs [16];
    int         npulse;
    logic       timed_out;
    logic [7:0] exp_q = 8'b1010_1100;

    jk_sequencer #(.CLK_HZ(10), .TICK_HZ(1), .SEQ_LEN(8)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .mode(mode), .start(start),
        .sw_j(sw_j), .sw_k(sw_k), .jk_q(jk_q), .jk_qbar(jk_qbar),
        .jk_j(jk_j), .jk_k(jk_k), .jk_en(jk_en), .step(step),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ff_q <= 1'b0;
        else if (jk_en) begin
            if (force_zero) ff_q <= 1'b0;
            else if (jk_j && jk_k) ff_q <= ~ff_q;
            else if (jk_j) ff_q <= 1'b1;
            else if (jk_k) ff_q <= 1'b0;
        end
    end
    assign jk_q    = ff_q;
    assign jk_qbar = ~ff_q;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; mode = 1'b0; start = 1'b0; sw_j = 1'b0; sw_k = 1'b0; force_zero = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one auto sequence, logging strobe cycles and flop q after each strobe.
    task automatic auto_run(input int force_idx, input bit hold_start, input bit restart3);
        bit pend = 0;
        bit sent = 0;
        npulse = 0;
        timed_out = 1'b1;
        @(negedge clk);
        mode = 1'b1; start = 1'b1;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!hold_start && c == 1) start = 1'b0;
            if (sent && start) start = 1'b0;
            if (pend) begin
                qs[npulse-1] = jk_q;
                pend = 0;
                force_zero = 1'b0;
            end
            if (jk_en && npulse < 16) begin
                pulse_cyc[npulse] = c;
                if (npulse == force_idx) force_zero = 1'b1;
                npulse++;
                pend = 1;
            end
            if (restart3 && !sent && busy && step == 3'd3) begin
                start = 1'b1;
                sent = 1;
            end
            if ((done || err) && !pend) begin
                timed_out = 1'b0;
                break;
            end
        end
        check_eq("run_timeout", timed_out, 0);
    endtask

    initial begin
        int n;
        logic got;

        // Reset state
        #2;
        check_eq("rst_outputs", {jk_j, jk_k, jk_en, step, busy, done, err}, 0);
        do_reset();

        // Full auto pass with start held high afterwards
        auto_run(-1, 1'b1, 1'b0);
        check_eq("pass_npulse", npulse, 8);
        check_eq("first_latency_ok", pulse_cyc[0] <= PER + 1, 1);
        for (int i = 1; i < 8; i++) check_eq($sformatf("pass_gap%0d", i), pulse_cyc[i] - pulse_cyc[i-1], PER);
        for (int i = 0; i < 8; i++) check_eq($sformatf("pass_q%0d", i), qs[i], exp_q[i]);
        check_eq("pass_done", done, 1);
        check_eq("pass_err", err, 0);
        check_eq("pass_step", step, 7);
        check_eq("pass_busy", busy, 0);
        repeat (25) @(negedge clk);
        check_eq("held_start_done", done, 1);
        check_eq("held_start_busy", busy, 0);
        check_eq("held_start_step", step, 7);
        start = 1'b0;

        // Flop forced low after step 2
        do_reset();
        auto_run(2, 1'b0, 1'b0);
        check_eq("force_q2", qs[2], 0);
`ifdef JK_SEQ_SELFCHECK_EN
        check_eq("fail_err", err, 1);
        check_eq("fail_step", step, 2);
        check_eq("fail_busy", busy, 0);
        check_eq("fail_done", done, 0);
        check_eq("fail_npulse", npulse, 3);
`else
        check_eq("nochk_done", done, 1);
        check_eq("nochk_err", err, 0);
        check_eq("nochk_step", step, 7);
        check_eq("nochk_npulse", npulse, 8);
`endif

        // Manual toggle for 4 ticks
        do_reset();
        sw_j = 1'b1; sw_k = 1'b1;
        n = 0;
        for (int c = 0; c < 80 && n < 4; c++) begin
            @(negedge clk);
            if (jk_en) begin
                @(negedge clk);
                check_eq($sformatf("man_q%0d", n), jk_q, (n % 2 == 0) ? 1 : 0);
                n++;
            end
        end
        check_eq("man_npulse", n, 4);
        check_eq("man_busy", busy, 0);

        // Abort during step 4 LOAD
        do_reset();
        @(negedge clk);
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (step == 3'd4) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("abort_reached", got, 1);
        check_eq("abort_busy_before", busy, 1);
        check_eq("abort_q_before", jk_q, 1);
        mode = 1'b0; sw_j = 1'b0; sw_k = 1'b0;
        @(negedge clk);
        check_eq("abort_idle", {step, busy, done, err}, 0);
        repeat (40) @(negedge clk);
        check_eq("abort_q_after", jk_q, 1);
        check_eq("abort_jk_after", {jk_j, jk_k}, 0);
        check_eq("abort_step_after", step, 0);

        // Second start edge at step 3 is ignored
        do_reset();
        auto_run(-1, 1'b0, 1'b1);
        check_eq("restart_npulse", npulse, 8);
        check_eq("restart_done", done, 1);
        check_eq("restart_step", step, 7);
        check_eq("restart_err", err, 0);

        // Asynchronous reset during STROBE, then tick phase restart
        do_reset();
        @(negedge clk);
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (jk_en) begin
                got = 1'b1;
                break;
            end
        end
        check_eq("strobe_reached", got, 1);
        #1 rst_n = 1'b0;
        #1;
        check_eq("async_rst_outputs", {jk_j, jk_k, jk_en, step, busy, done, err}, 0);
        check_eq("async_rst_flop", jk_q, 0);
        mode = 1'b0; sw_j = 1'b1; sw_k = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (jk_en) begin
                n = c;
                break;
            end
        end
        check_eq("tick_restart_cycle", n, PER - 1);
        check_eq("post_rst_manual_j", jk_j, 1);
        check_eq("post_rst_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jk_sequencer.md
# jk_sequencer

Controller that sequences a J-K flip-flop on the DE2 board. It generates a slow tick enable from CLOCK_50 and has two modes. In manual mode, the board switches drive J/K. In auto mode, a fixed 8-step J/K pattern is applied one step per tick. A reference model checks the flop's q/qbar after every strobe and reports PASS or FAIL. It sits between the board I/O (switches, keys, LEDs) and a CLOCK_50-clocked, enable-gated J-K flop.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- TICK_HZ, 1, step rate; tick period = CLK_HZ/TICK_HZ cycles (integer, ≥2)
- SEQ_LEN, 8, auto-pattern length (fixed at 8; the step counter is 3 bits)

- CLOCK_50  in  1  system clock; all logic on its rising edge
- RESET_N  in  1  asynchronous, active-low reset
- mode  in  1  0 = manual, 1 = auto
- start  in  1  auto run request; rising edge detected internally
- sw_j, sw_k  in  1 each  manual J/K
- jk_q, jk_qbar  in  1 each  flop outputs fed back
- jk_j, jk_k  out  1 each  J/K driven to the flop
- jk_en  out  1  one-cycle flop enable
- step  out  3  current auto step index
- busy  out  1  auto run in progress
- done  out  1  PASS: run completed without mismatch
- err  out  1  FAIL: mismatch detected (sticky until cleared)

## Operation
- Reset values: jk_j=0, jk_k=0, jk_en=0, step=0, busy=0, done=0, err=0, state=IDLE, model q=0, tick counter=0. The flop is also reset to q=0 by RESET_N.
- Tick generator: 32-bit counter counts 0..CLK_HZ/TICK_HZ-1 and wraps. The tick is high for exactly one cycle, in the cycle where the count equals the terminal value. The counter is free-running and never restarted by the FSM.
- Command encoding (J,K): 00 hold, 01 reset, 10 set, 11 toggle.
- Auto pattern, steps 0..7: reset, hold, set, hold, toggle, toggle, reset, toggle. Expected q after each step: 0,0,1,1,0,1,0,1.
- Model: on every jk_en pulse, model q updates per J/K with the same rules as the flop.
- FSM states:
  - IDLE. With mode=0, jk_j=sw_j, jk_k=sw_k and jk_en=tick. With mode=1 and a start rising edge, clear done and err, set step=0 and go to LOAD.
  - LOAD. Drive J/K from pattern[step] and set busy=1. On tick, go to STROBE.
  - STROBE. jk_en=1 for this single cycle and the model updates. Next state is CHECK.
  - CHECK. Compare jk_q against model q and jk_qbar against its inverse.
    - On mismatch, go to FAIL.
    - Otherwise, if step=7 go to PASS; else increment step and go to LOAD.
  - PASS. done=1, busy=0.
  - FAIL. err=1, busy=0, step frozen at the failing index.
  - From PASS or FAIL: a start rising edge begins a new run; mode=0 returns to IDLE.
- Boundaries:
  - A start edge while busy is ignored.
  - start held high does not retrigger; a new rising edge is required.
  - mode→0 during LOAD, STROBE or CHECK aborts to IDLE on the next cycle: step=0, busy=0, done=0, err=0. The model is retained.
  - The model also tracks manual-mode strobes, so an auto run starts from a known state.
  - RESET_N asserted at any point returns all outputs to their reset values immediately (asynchronously).

## Timing
- Start edge (cycle n) → LOAD at n+1. The first jk_en occurs in the cycle after the first tick seen in LOAD, i.e. at most one tick period + 2 cycles after the start edge.
- jk_en → flop updates at the end of that cycle → compare occurs the next cycle (CHECK).
- Steps are spaced exactly one tick period apart.
- A full pass asserts done 8 ticks + ≤2 tick periods after start.
- Outputs are registered, except jk_en in manual mode, which equals the registered tick.

## Configuration
- JK_SEQ_SELFCHECK_EN
  - Defined: model comparison active; FAIL reachable; err behaves as above.
  - Undefined: CHECK always passes, err is tied to 0, the FAIL state and model are removed, and done still asserts after step 7.

## Structure
- Package jk_seq_pkg:
  - FSM state enum
  - J/K command encoding constants
  - 8-entry pattern and expected-q constant arrays
- Sub-module jk_tick_gen: parameterized CLK_HZ/TICK_HZ counter producing a one-cycle tick.
- FSM and model live in jk_sequencer.

## Test plan
- CLK_HZ=10, TICK_HZ=1, mode=1, start pulse, correct flop → jk_en pulses 10 cycles apart, jk_q sequence 0,0,1,1,0,1,0,1, then done=1, err=0, step=7.
- Same setup, but the flop is forced to q=0 after step 2 → err=1 with step=2, busy=0, done=0.
- mode=0, sw_j=1, sw_k=1 for 4 ticks → 4 jk_en pulses, q toggles 1,0,1,0, busy=0.
- Auto run, then mode=0 during step 4 LOAD → next cycle IDLE, step=0, busy=0, no further pattern strobes.
- Second start edge while busy at step 3 → ignored; run completes with done=1 at step 7.
- RESET_N low mid-STROBE → all outputs 0 immediately; after release, IDLE and tick count restarts from 0.
